// File: rtl/addsub_if.sv
// addsub_if: the operand/result bus of pipelined_addsub.
//
// Carries the input handshake (in_valid/in_ready plus operands and opcode
// bits), the output handshake (out_valid/out_ready plus result flags) and
// the pipeline flush request. clk and rst are not part of the bus.
//
// Modports
//   master : the side that issues operands and consumes results
//   slave  : the add/sub unit itself
//
// Parameter
//   WIDTH  operand/result width in bits
interface addsub_if #(
   parameter int WIDTH = 32
);
   logic             flush;      // drop everything in flight
   logic             in_valid;   // operand set present
   logic             in_ready;   // unit can take operands this cycle
   logic [WIDTH-1:0] op_a;       // operand A
   logic [WIDTH-1:0] op_b;       // operand B
   logic             sub;        // 0: A+B, 1: A-B
   logic             signed_op;  // 1: report signed overflow
   logic             out_valid;  // result present
   logic             out_ready;  // consumer takes result this cycle
   logic [WIDTH-1:0] res;        // result
   logic             carry_out;  // carry out of MSB (sub: 1 = no borrow)
   logic             overflow;   // signed two's-complement overflow

   modport master (
      output flush, in_valid, op_a, op_b, sub, signed_op, out_ready,
      input  in_ready, out_valid, res, carry_out, overflow
   );

   modport slave (
      input  flush, in_valid, op_a, op_b, sub, signed_op, out_ready,
      output in_ready, out_valid, res, carry_out, overflow
   );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit adder/subtractor split into STAGES carry-linked
// slices, one slice per pipeline stage, with a valid/ready handshake.
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (drops every in-flight result)
//   bus   addsub_if.slave:
//           flush, in_valid/in_ready, op_a, op_b, sub, signed_op  (input side)
//           out_valid/out_ready, res, carry_out, overflow          (output side)
//
// Parameters
//   WIDTH   operand/result width
//   STAGES  pipeline depth; WIDTH must be a multiple of STAGES
//
// Optional feature
//   ADDSUB_SAT_EN  when defined, a signed overflow saturates res to the
//                  most negative / most positive value (selected by the sign
//                  of op_a); overflow stays asserted and carry_out stays raw.
//
// Operation
//   B' = sub ? ~op_b : op_b, carry-in = sub. Stage k adds slice k of A and B'
//   plus the carry registered by stage k-1. Operands travel down the pipe so
//   later stages still see the upper slices and the MSBs needed for the
//   overflow rule. All stages move together when the output slot is empty or
//   being consumed; otherwise the whole pipe holds.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic    clk,
   input  logic    rst,
   addsub_if.slave bus
);

   localparam int S    = WIDTH / STAGES;   // slice width
   localparam int LAST = STAGES - 1;

   // Low S bits set; shifted into place to mask out one slice of the sum.
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({S{1'b1}});
   localparam logic [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MOST_POS   = {1'b0, {(WIDTH-1){1'b1}}};

   generate
      if ((WIDTH % STAGES) != 0) begin : g_bad_params
         $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)",
                WIDTH, STAGES);
      end
   endgenerate

   // ------------------------------------------------------------------
   // Stage registers. Index k is the register at the end of stage k+1.
   // ------------------------------------------------------------------
   logic [STAGES-1:0] vld_reg;             // slot holds a live operation
   logic [STAGES-1:0] cy_reg;              // carry out of slice k
   logic [STAGES-1:0] sgn_reg;             // signed_op travelling with the op
   logic [WIDTH-1:0]  a_reg   [STAGES];    // operand A
   logic [WIDTH-1:0]  b_reg   [STAGES];    // operand B' (already inverted for sub)
   logic [WIDTH-1:0]  sum_reg [STAGES];    // slices 0..k valid, upper bits don't care

   // Next-state values computed per stage.
   logic [STAGES-1:0] vld_next;
   logic [STAGES-1:0] cy_next;
   logic [STAGES-1:0] sgn_next;
   logic [WIDTH-1:0]  a_next   [STAGES];
   logic [WIDTH-1:0]  b_next   [STAGES];
   logic [WIDTH-1:0]  sum_next [STAGES];

   // Whole pipe moves when the output slot is free or is being taken.
   logic adv;
   assign adv          = !vld_reg[LAST] || bus.out_ready;
   assign bus.in_ready = adv;

   // ------------------------------------------------------------------
   // One slice adder per stage.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [WIDTH-1:0] a_src;
         logic [WIDTH-1:0] b_src;
         logic [WIDTH-1:0] sum_src;
         logic             cin_src;
         logic             sgn_src;
         logic             vld_src;
         logic [S:0]       slice;   // {carry, S-bit slice sum}

         if (gi == 0) begin : g_head
            // First stage takes operands straight off the bus; the subtract
            // carry-in is the +1 of the two's-complement negation.
            assign a_src   = bus.op_a;
            assign b_src   = bus.sub ? ~bus.op_b : bus.op_b;
            assign sum_src = '0;
            assign cin_src = bus.sub;
            assign sgn_src = bus.signed_op;
            assign vld_src = bus.in_valid;
         end else begin : g_link
            assign a_src   = a_reg[gi-1];
            assign b_src   = b_reg[gi-1];
            assign sum_src = sum_reg[gi-1];
            assign cin_src = cy_reg[gi-1];
            assign sgn_src = sgn_reg[gi-1];
            assign vld_src = vld_reg[gi-1];
         end

         assign slice = {1'b0, a_src[gi*S +: S]}
                      + {1'b0, b_src[gi*S +: S]}
                      + {{S{1'b0}}, cin_src};

         // Splice this stage's slice into the partial sum.
         assign sum_next[gi] = (sum_src & ~(SLICE_MASK << (gi*S)))
                             | (WIDTH'(slice[S-1:0]) << (gi*S));
         assign cy_next[gi]  = slice[S];
         assign a_next[gi]   = a_src;
         assign b_next[gi]   = b_src;
         assign sgn_next[gi] = sgn_src;
         assign vld_next[gi] = vld_src;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Stage register update.
   // Flush clears only the valid bits, and wins over both accept and hold;
   // data registers are allowed to keep stale contents.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_reg <= '0;
         cy_reg  <= '0;
         sgn_reg <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_reg[k]   <= '0;
            b_reg[k]   <= '0;
            sum_reg[k] <= '0;
         end
      end else begin
         if (bus.flush) begin
            vld_reg <= '0;
         end else if (adv) begin
            vld_reg <= vld_next;
         end

         if (adv) begin
            cy_reg  <= cy_next;
            sgn_reg <= sgn_next;
            for (int k = 0; k < STAGES; k++) begin
               a_reg[k]   <= a_next[k];
               b_reg[k]   <= b_next[k];
               sum_reg[k] <= sum_next[k];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output stage: overflow rule and optional saturation, taken from the
   // last stage register so results hold steady while the pipe is stalled.
   // ------------------------------------------------------------------
   logic             a_msb;
   logic             b_msb;
   logic             ovf;
   logic [WIDTH-1:0] res_raw;

   assign res_raw = sum_reg[LAST];
   assign a_msb   = a_reg[LAST][WIDTH-1];
   assign b_msb   = b_reg[LAST][WIDTH-1];

   // Operands of equal sign whose sum has the other sign overflowed.
   assign ovf = sgn_reg[LAST] && (a_msb == b_msb) && (res_raw[WIDTH-1] != a_msb);

`ifdef ADDSUB_SAT_EN
   // A negative first operand can only overflow downward, so its sign picks
   // the saturation limit.
   assign bus.res = ovf ? (a_msb ? MOST_NEG : MOST_POS) : res_raw;
`else
   assign bus.res = res_raw;
`endif

   assign bus.out_valid = vld_reg[LAST];
   assign bus.carry_out = cy_reg[LAST];
   assign bus.overflow  = ovf;

   // Limits are only referenced when saturation is built in.
   logic unused_limits;
   assign unused_limits = ^{MOST_NEG, MOST_POS};

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed self-checking bench for pipelined_addsub
// with WIDTH=32, STAGES=4. Expected values are hand-computed constants.
module tb_pipelined_addsub;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   addsub_if #(.WIDTH(W)) bus ();

   pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

`ifdef ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // Advance one clock; inputs are driven and outputs sampled 1 time unit
   // after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.sub       = 1'b0;
      bus.signed_op = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   // Issue one operation into an empty pipe and wait (bounded) for its
   // result; lat is the number of edges from and including the accept edge.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic g,
                        output logic [W-1:0] r, output logic c,
                        output logic o, output int lat);
      bus.op_a      = a;
      bus.op_b      = b;
      bus.sub       = s;
      bus.signed_op = g;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 12) begin
         tick();
         lat++;
      end
      r = bus.res;
      c = bus.carry_out;
      o = bus.overflow;
      tick();   // result consumed on this edge
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid_in_reset: got %b want 0", bus.out_valid); else pass_cnt++;
      rst = 1'b0;
      tick();
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.res !== 32'h0) $display("FAIL reset_res: got %h want 00000000", bus.res); else pass_cnt++;
      total_cnt++; if (bus.carry_out !== 1'b0) $display("FAIL reset_carry: got %b want 0", bus.carry_out); else pass_cnt++;
      total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else pass_cnt++;
      $display("reset: out_valid=%b res=%h in_ready=%b", bus.out_valid, bus.res, bus.in_ready);
   endtask

   task automatic test_add();
      logic [W-1:0] r; logic c, o; int lat;
      do_op(32'd5, 32'd7, 1'b0, 1'b0, r, c, o, lat);
      $display("add 5+7: res=%h c=%b ov=%b lat=%0d", r, c, o, lat);
      total_cnt++; if (lat !== 4) $display("FAIL add_latency: got %0d want 4", lat); else pass_cnt++;
      total_cnt++; if (r !== 32'd12) $display("FAIL add_res: got %h want 0000000c", r); else pass_cnt++;
      total_cnt++; if (c !== 1'b0) $display("FAIL add_carry: got %b want 0", c); else pass_cnt++;
      total_cnt++; if (o !== 1'b0) $display("FAIL add_overflow: got %b want 0", o); else pass_cnt++;
   endtask

   task automatic test_overflow();
      logic [W-1:0] r; logic c, o; int lat;
      do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, r, c, o, lat);
      $display("add 7fffffff+1 signed: res=%h c=%b ov=%b", r, c, o);
      total_cnt++; if (r !== (SAT ? 32'h7FFF_FFFF : 32'h8000_0000)) $display("FAIL ovf_add_res: got %h want %h", r, SAT ? 32'h7FFF_FFFF : 32'h8000_0000); else pass_cnt++;
      total_cnt++; if (o !== 1'b1) $display("FAIL ovf_add_flag: got %b want 1", o); else pass_cnt++;
      total_cnt++; if (c !== 1'b0) $display("FAIL ovf_add_carry: got %b want 0", c); else pass_cnt++;
      do_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, r, c, o, lat);
      $display("add 7fffffff+1 unsigned: res=%h c=%b ov=%b", r, c, o);
      total_cnt++; if (r !== 32'h8000_0000) $display("FAIL addu_res: got %h want 80000000", r); else pass_cnt++;
      total_cnt++; if (o !== 1'b0) $display("FAIL addu_overflow: got %b want 0", o); else pass_cnt++;
   endtask

   task automatic test_sub();
      logic [W-1:0] r; logic c, o; int lat;
      do_op(32'd3, 32'd5, 1'b1, 1'b1, r, c, o, lat);
      $display("sub 3-5: res=%h c=%b ov=%b", r, c, o);
      total_cnt++; if (r !== 32'hFFFF_FFFE) $display("FAIL sub_res: got %h want fffffffe", r); else pass_cnt++;
      total_cnt++; if (c !== 1'b0) $display("FAIL sub_carry: got %b want 0", c); else pass_cnt++;
      total_cnt++; if (o !== 1'b0) $display("FAIL sub_overflow: got %b want 0", o); else pass_cnt++;
      do_op(32'h8000_0000, 32'd1, 1'b1, 1'b1, r, c, o, lat);
      $display("sub 80000000-1 signed: res=%h c=%b ov=%b", r, c, o);
      total_cnt++; if (r !== (SAT ? 32'h8000_0000 : 32'h7FFF_FFFF)) $display("FAIL ovf_sub_res: got %h want %h", r, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF); else pass_cnt++;
      total_cnt++; if (o !== 1'b1) $display("FAIL ovf_sub_flag: got %b want 1", o); else pass_cnt++;
      total_cnt++; if (c !== 1'b1) $display("FAIL ovf_sub_carry: got %b want 1", c); else pass_cnt++;
   endtask

   task automatic test_wrap();
      logic [W-1:0] r; logic c, o; int lat;
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, r, c, o, lat);
      $display("add ffffffff+1: res=%h c=%b ov=%b", r, c, o);
      total_cnt++; if (r !== 32'h0) $display("FAIL wrap_res: got %h want 00000000", r); else pass_cnt++;
      total_cnt++; if (c !== 1'b1) $display("FAIL wrap_carry: got %b want 1", c); else pass_cnt++;
      total_cnt++; if (o !== 1'b0) $display("FAIL wrap_overflow: got %b want 0", o); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] ta [8] = '{32'd1, 32'h0000_FFFF, 32'd100, 32'hFFFF_0000,
                               32'd7, 32'h1234_5678, 32'd0,  32'h4000_0000};
      logic [W-1:0] tb [8] = '{32'd2, 32'd1,         32'd30,  32'h0001_0000,
                               32'd7, 32'h1111_1111, 32'd1,  32'h4000_0000};
      logic         ts [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [W-1:0] te [8] = '{32'd3, 32'h0001_0000, 32'd70,  32'h0,
                               32'h0, 32'h2345_6789, 32'hFFFF_FFFF, 32'h8000_0000};
      logic         tc [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      int  sent = 0;
      int  recv = 0;
      int  extra = 0;
      bit  stall;
      bit  acc;
      idle_inputs();
      for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
         stall = (cyc >= 6 && cyc <= 8);
         bus.out_ready = !stall;
         bus.in_valid  = (sent < 8);
         if (sent < 8) begin
            bus.op_a = ta[sent];
            bus.op_b = tb[sent];
            bus.sub  = ts[sent];
         end
         #1;
         if (stall) begin
            total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_stall_in_ready cyc %0d: got %b want 0", cyc, bus.in_ready); else pass_cnt++;
            total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_stall_out_valid cyc %0d: got %b want 1", cyc, bus.out_valid); else pass_cnt++;
            total_cnt++; if (bus.res !== te[recv]) $display("FAIL b2b_stall_hold cyc %0d: got %h want %h", cyc, bus.res, te[recv]); else pass_cnt++;
         end else begin
            total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc %0d: got %b want 1", cyc, bus.in_ready); else pass_cnt++;
         end
         if (bus.out_valid && bus.out_ready) begin
            $display("b2b result %0d: res=%h c=%b ov=%b", recv, bus.res, bus.carry_out, bus.overflow);
            total_cnt++; if (bus.res !== te[recv]) $display("FAIL b2b_res %0d: got %h want %h", recv, bus.res, te[recv]); else pass_cnt++;
            total_cnt++; if (bus.carry_out !== tc[recv]) $display("FAIL b2b_carry %0d: got %b want %b", recv, bus.carry_out, tc[recv]); else pass_cnt++;
            total_cnt++; if (bus.overflow !== 1'b0) $display("FAIL b2b_overflow %0d: got %b want 0", recv, bus.overflow); else pass_cnt++;
            recv++;
         end
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) sent++;
      end
      total_cnt++; if (recv !== 8) $display("FAIL b2b_count: got %0d want 8", recv); else pass_cnt++;
      idle_inputs();
      for (int i = 0; i < 6; i++) begin
         if (bus.out_valid) extra++;
         tick();
      end
      total_cnt++; if (extra !== 0) $display("FAIL b2b_duplicates: got %0d want 0", extra); else pass_cnt++;
   endtask

   // Fill three stages, then hit them with flush (or rst) while in_valid=1.
   task automatic fill_three();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         bus.op_a     = 32'd10 * (i + 1);
         bus.op_b     = 32'd1;
         bus.in_valid = 1'b1;
         tick();
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] r; logic c, o; int lat;
      int pulses = 0;
      fill_three();
      bus.flush = 1'b1;
      bus.op_a  = 32'd99;
      tick();
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         if (bus.out_valid) pulses++;
         tick();
      end
      total_cnt++; if (pulses !== 0) $display("FAIL flush_stale: got %0d pulses want 0", pulses); else pass_cnt++;
      do_op(32'd20, 32'd8, 1'b1, 1'b0, r, c, o, lat);
      $display("after flush 20-8: res=%h c=%b lat=%0d", r, c, lat);
      total_cnt++; if (lat !== 4) $display("FAIL flush_next_latency: got %0d want 4", lat); else pass_cnt++;
      total_cnt++; if (r !== 32'd12) $display("FAIL flush_next_res: got %h want 0000000c", r); else pass_cnt++;
      total_cnt++; if (c !== 1'b1) $display("FAIL flush_next_carry: got %b want 1", c); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] r; logic c, o; int lat;
      int pulses = 0;
      fill_three();
      rst = 1'b1;
      #1;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); else pass_cnt++;
      tick();
      rst = 1'b0;
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         if (bus.out_valid) pulses++;
         tick();
      end
      total_cnt++; if (pulses !== 0) $display("FAIL rstmid_stale: got %0d pulses want 0", pulses); else pass_cnt++;
      do_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, r, c, o, lat);
      $display("after reset 11111111+22222222: res=%h c=%b ov=%b lat=%0d", r, c, o, lat);
      total_cnt++; if (lat !== 4) $display("FAIL rstmid_next_latency: got %0d want 4", lat); else pass_cnt++;
      total_cnt++; if (r !== 32'h3333_3333) $display("FAIL rstmid_next_res: got %h want 33333333", r); else pass_cnt++;
      total_cnt++; if (o !== 1'b0) $display("FAIL rstmid_next_overflow: got %b want 0", o); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_overflow();
      test_sub();
      test_wrap();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
